ddr3_rw_arbiter: RTL
====================

# ddr3_rw_arbiter

Burst scheduler between the DDR3 user port and the two frame-buffer FIFOs: the Ethernet write FIFO and the LCD read FIFO. It decides which side gets the next DDR3 burst and generates the burst addresses. It also handles frame wrap, frame reload and ping-pong bank selection. It sits inside the DDR3 control top, in the DDR3 user clock domain, between the FIFO level counters and the DDR3 burst command engine.

## Interface
Parameters:
- FIFO_CNT_W, 11, width of FIFO level inputs (128-bit words)
- RFIFO_DEPTH, 1024, read FIFO capacity in 128-bit words

Ports:
- clk  in  1  DDR3 user clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ddr3_init_done  in  1  DDR3 calibration complete
- wfifo_rcount  in  FIFO_CNT_W  words available in write FIFO
- rfifo_wcount  in  FIFO_CNT_W  words held in read FIFO
- wr_load, rd_load  in  1  frame reload levels, already synchronised to clk
- ddr3_pingpang_en  in  1  enable two-bank ping-pong
- ddr3_read_valid  in  1  0 blocks all read bursts
- addr_wr_min, addr_wr_max, addr_rd_min, addr_rd_max  in  28  pixel address window; max is exclusive
- wr_burst_len, rd_burst_len  in  10  burst length in 128-bit beats (8 pixels per beat)
- wr_cmd_req  out  1  write burst request
- wr_cmd_addr  out  28  write burst start address; bit 27 is the bank
- wr_cmd_len  out  10  write burst length
- wr_cmd_ack  in  1  write command accepted
- wr_done  in  1  one-cycle pulse: write burst finished
- rd_cmd_req, rd_cmd_addr (28), rd_cmd_len (10), rd_cmd_ack, rd_done: same scheme for reads

## Operation
State machine: IDLE, ARB, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT.

**IDLE**
- Pointers load continuously: wr_ptr←addr_wr_min, rd_ptr←addr_rd_min, both banks←0.
- Moves to ARB the first cycle ddr3_init_done=1.

**ARB eligibility**
- Write side is eligible when wr_burst_len≠0 and wfifo_rcount ≥ wr_burst_len.
- Read side is eligible when ddr3_read_valid=1, rd_burst_len≠0 and rfifo_wcount ≤ RFIFO_DEPTH − rd_burst_len.

**ARB grant rules**
- Only one side eligible: that side is granted.
- Both eligible, rfifo_wcount < rd_burst_len (urgent): read is granted.
- Both eligible, not urgent: the side not granted last time wins. The last_grant register resets to "read".
- Neither eligible: stay in ARB.

**Request and wait**
- WR_REQ / RD_REQ: req=1; addr and len are held stable. Move to the WAIT state on the cycle ack=1.
- WR_WAIT / RD_WAIT: wait for done. On done, advance the pointer and return to ARB.

**Pointer advance**
- step = len<<3.
- If ptr+step ≥ max: ptr←min (wrap). Otherwise ptr←ptr+step.
- Sums are computed 29 bits wide; no overflow is possible.

**Banks**
- Bank bits stay 0 when ddr3_pingpang_en=0.
- wr_cmd_addr = {wr_bank, wr_ptr[26:0]}; rd_cmd_addr = {rd_bank, rd_ptr[26:0]}.
- Write wrap with ping-pong enabled: wr_bank toggles.
- Read wrap with ping-pong enabled: rd_bank←~wr_bank, i.e. the last completed frame is read.

**Loads**
- A rising edge on wr_load / rd_load (detected against a registered copy) sets a pending flag.
- The pending flag is applied only in IDLE or ARB, never mid-burst:
  - wr: wr_ptr←addr_wr_min.
  - rd: rd_ptr←addr_rd_min, and rd_bank←~wr_bank when ping-pong is enabled.
- The flag clears when applied. A load pending in ARB is applied before that cycle's grant.
- A load and a wrap in the same cycle: the load wins for the pointer; the wrap bank rule still applies.

**Init loss and reset**
- ddr3_init_done falling in any state: return to IDLE at the next edge and drop req. Commands already issued are abandoned.
- rst_n=0 at any edge forces IDLE and reset values, including mid-burst.

## Timing
- Reset values: wr_cmd_req=0, rd_cmd_req=0, wr_cmd_addr=0, rd_cmd_addr=0, wr_cmd_len=0, rd_cmd_len=0; pending flags 0; last_grant=read.
- All outputs are registered.
- req rises one cycle after the ARB cycle that granted.
- req falls on the cycle after ack is sampled high.
- addr and len are valid on the first cycle req=1 and do not change until req drops.
- The pointer update is visible one cycle after done, and ARB is re-entered on that cycle.
- Minimum back-to-back gap: done → next req = 2 cycles.
- ack is ignored outside the REQ states; done is ignored outside the WAIT states.
- Read and write req are never high together.

## Test plan
- **Reset/init:** hold ddr3_init_done=0 → both req=0. Raise it with wfifo_rcount=100, wr_burst_len=100 → wr_cmd_req high 2 cycles later, wr_cmd_addr=addr_wr_min=0, wr_cmd_len=100.
- **Wrap:** addr_wr_max=2400, wr_burst_len=100 (step 800); run 3 bursts → addresses 0, 800, 1600, then 0. With ping-pong enabled, the fourth address has bit 27=1.
- **Arbitration:** both sides eligible, rfifo_wcount=500, rd_burst_len=100 → grants alternate W,R,W,R starting with W. Set rfifo_wcount=50 (urgent) → read is granted in two consecutive arbitrations.
- **Read gating:** ddr3_read_valid=0 with read eligible → rd_cmd_req stays 0 for 1000 cycles.
- **Load mid-burst:** pulse rd_load during RD_WAIT at rd_ptr=800 → the current burst completes, then the next rd_cmd_addr=addr_rd_min. With ping-pong enabled and wr_bank=1 → next rd_cmd_addr bit 27=0.
- **Reset mid-burst:** assert rst_n=0 for 1 cycle during WR_REQ → wr_cmd_req=0 and wr_cmd_addr=0 next cycle. A late wr_done is ignored.

Source files
------------

// File: rtl/ddr3_rw_arbiter.sv
// ddr3_rw_arbiter
// Burst scheduler between the DDR3 burst command engine and the two
// frame-buffer FIFOs (Ethernet write FIFO, LCD read FIFO). It picks the side
// that gets the next burst, generates burst start addresses inside each
// side's pixel window, wraps at the window end, applies frame reloads, and
// manages ping-pong bank selection (address bit 27).
//
// Ports
//   clk, rst_n                  DDR3 user clock, synchronous active-low reset
//   ddr3_init_done              calibration done; low forces IDLE
//   wfifo_rcount / rfifo_wcount FIFO levels in 128-bit words
//   wr_load / rd_load           frame reload levels (rising edge = reload)
//   ddr3_pingpang_en            enable two-bank ping-pong
//   ddr3_read_valid             0 blocks all read bursts
//   addr_{wr,rd}_{min,max}      pixel address windows, max exclusive
//   {wr,rd}_burst_len           burst length in 128-bit beats
//   {wr,rd}_cmd_req/addr/len    registered burst command outputs
//   {wr,rd}_cmd_ack             command accepted
//   {wr,rd}_done                one-cycle burst-finished pulse
module ddr3_rw_arbiter #(
    parameter int FIFO_CNT_W  = 11,
    parameter int RFIFO_DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ddr3_init_done,
    input  logic [FIFO_CNT_W-1:0] wfifo_rcount,
    input  logic [FIFO_CNT_W-1:0] rfifo_wcount,
    input  logic                  wr_load,
    input  logic                  rd_load,
    input  logic                  ddr3_pingpang_en,
    input  logic                  ddr3_read_valid,
    input  logic [27:0]           addr_wr_min,
    input  logic [27:0]           addr_wr_max,
    input  logic [27:0]           addr_rd_min,
    input  logic [27:0]           addr_rd_max,
    input  logic [9:0]            wr_burst_len,
    input  logic [9:0]            rd_burst_len,
    output logic                  wr_cmd_req,
    output logic [27:0]           wr_cmd_addr,
    output logic [9:0]            wr_cmd_len,
    input  logic                  wr_cmd_ack,
    input  logic                  wr_done,
    output logic                  rd_cmd_req,
    output logic [27:0]           rd_cmd_addr,
    output logic [9:0]            rd_cmd_len,
    input  logic                  rd_cmd_ack,
    input  logic                  rd_done
);

    typedef enum logic [2:0] {
        IDLE, ARB, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [27:0] wr_ptr, rd_ptr;
    logic        wr_bank, rd_bank;
    logic        wr_load_q, rd_load_q;
    logic        wr_load_pend, rd_load_pend;
    logic        last_grant_rd;   // 1: last grant went to read

    logic        wr_elig, rd_elig, rd_urgent;
    logic        grant_wr, grant_rd;

    // Eligibility compares done in 32 bits so the depth subtraction can
    // never underflow: wcount <= DEPTH - len  <=>  wcount + len <= DEPTH.
    assign wr_elig   = (wr_burst_len != 10'd0) &&
                       (32'(wfifo_rcount) >= 32'(wr_burst_len));
    assign rd_elig   = ddr3_read_valid && (rd_burst_len != 10'd0) &&
                       (32'(rfifo_wcount) + 32'(rd_burst_len) <= 32'(RFIFO_DEPTH));
    assign rd_urgent = 32'(rfifo_wcount) < 32'(rd_burst_len);

    // Pointer advance, 29 bits wide so ptr + step cannot overflow.
    logic [28:0] wr_sum, rd_sum;
    logic        wr_wrap, rd_wrap;
    assign wr_sum  = {1'b0, wr_ptr} + {16'd0, wr_cmd_len, 3'd0};
    assign rd_sum  = {1'b0, rd_ptr} + {16'd0, rd_cmd_len, 3'd0};
    assign wr_wrap = wr_sum >= {1'b0, addr_wr_max};
    assign rd_wrap = rd_sum >= {1'b0, addr_rd_max};

    // A pending reload is applied in ARB before the grant, so the granted
    // address must already see the reloaded pointer/bank.
    logic [27:0] wr_ptr_cur, rd_ptr_cur;
    logic        wr_bank_cur, rd_bank_cur;
    assign wr_ptr_cur  = wr_load_pend ? addr_wr_min : wr_ptr;
    assign rd_ptr_cur  = rd_load_pend ? addr_rd_min : rd_ptr;
    assign wr_bank_cur = ddr3_pingpang_en & wr_bank;
    assign rd_bank_cur = ddr3_pingpang_en & (rd_load_pend ? ~wr_bank : rd_bank);

    logic load_window;
    assign load_window = (state == IDLE) || (state == ARB);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        case (state)
            IDLE: if (ddr3_init_done) state_nxt = ARB;
            ARB: begin
                if (wr_elig && rd_elig) begin
                    // Urgent read starves the LCD otherwise; else alternate.
                    if (rd_urgent || !last_grant_rd) grant_rd = 1'b1;
                    else                             grant_wr = 1'b1;
                end else if (wr_elig) begin
                    grant_wr = 1'b1;
                end else if (rd_elig) begin
                    grant_rd = 1'b1;
                end
                if (grant_wr) state_nxt = WR_REQ;
                if (grant_rd) state_nxt = RD_REQ;
            end
            WR_REQ:  if (wr_cmd_ack) state_nxt = WR_WAIT;
            WR_WAIT: if (wr_done)    state_nxt = ARB;
            RD_REQ:  if (rd_cmd_ack) state_nxt = RD_WAIT;
            RD_WAIT: if (rd_done)    state_nxt = ARB;
            default: state_nxt = IDLE;
        endcase
        // Calibration loss abandons whatever is in flight.
        if (!ddr3_init_done) begin
            state_nxt = IDLE;
            grant_wr  = 1'b0;
            grant_rd  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            wr_load_q     <= 1'b0;
            rd_load_q     <= 1'b0;
            wr_load_pend  <= 1'b0;
            rd_load_pend  <= 1'b0;
            last_grant_rd <= 1'b1;
            wr_cmd_req    <= 1'b0;
            rd_cmd_req    <= 1'b0;
            wr_cmd_addr   <= '0;
            rd_cmd_addr   <= '0;
            wr_cmd_len    <= '0;
            rd_cmd_len    <= '0;
        end else begin
            wr_load_q <= wr_load;
            rd_load_q <= rd_load;

            // A new edge beats a same-cycle clear so it is never lost.
            if (wr_load && !wr_load_q) wr_load_pend <= 1'b1;
            else if (load_window)      wr_load_pend <= 1'b0;
            if (rd_load && !rd_load_q) rd_load_pend <= 1'b1;
            else if (load_window)      rd_load_pend <= 1'b0;

            case (state)
                IDLE: begin
                    wr_ptr  <= addr_wr_min;
                    rd_ptr  <= addr_rd_min;
                    wr_bank <= 1'b0;
                    rd_bank <= 1'b0;
                end
                ARB: begin
                    if (wr_load_pend) wr_ptr <= addr_wr_min;
                    if (rd_load_pend) begin
                        rd_ptr  <= addr_rd_min;
                        rd_bank <= rd_bank_cur;
                    end
                end
                WR_WAIT: if (wr_done) begin
                    if (wr_wrap) begin
                        wr_ptr  <= addr_wr_min;
                        wr_bank <= ddr3_pingpang_en & ~wr_bank;
                    end else begin
                        wr_ptr  <= wr_sum[27:0];
                    end
                end
                RD_WAIT: if (rd_done) begin
                    if (rd_wrap) begin
                        rd_ptr  <= addr_rd_min;
                        // Read side follows the frame the writer just finished.
                        rd_bank <= ddr3_pingpang_en & ~wr_bank;
                    end else begin
                        rd_ptr  <= rd_sum[27:0];
                    end
                end
                default: ;
            endcase

            if (!ddr3_pingpang_en) begin
                wr_bank <= 1'b0;
                rd_bank <= 1'b0;
            end

            wr_cmd_req <= (state_nxt == WR_REQ);
            rd_cmd_req <= (state_nxt == RD_REQ);

            if (grant_wr) begin
                wr_cmd_addr   <= {wr_bank_cur, wr_ptr_cur[26:0]};
                wr_cmd_len    <= wr_burst_len;
                last_grant_rd <= 1'b0;
            end
            if (grant_rd) begin
                rd_cmd_addr   <= {rd_bank_cur, rd_ptr_cur[26:0]};
                rd_cmd_len    <= rd_burst_len;
                last_grant_rd <= 1'b1;
            end
        end
    end

endmodule
